// File: rtl/ascon_ctrl_pkg.sv
// Shared definitions for the Ascon encryption sequencer: FSM state
// encoding, the last round-constant index and default round counts.
package ascon_ctrl_pkg;

  localparam int ROUND_LAST       = 11;
  localparam int ROUNDS_A_DEFAULT = 12;
  localparam int ROUNDS_B_DEFAULT = 6;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    PA_INIT = 4'd2,
    WAIT_AD = 4'd3,
    PB_AD   = 4'd4,
    WAIT_PT = 4'd5,
    PB_PT   = 4'd6,
    FINAL   = 4'd7,
    END     = 4'd8
  } ctrl_state_t;

  // First round-constant index for a permutation of the given length,
  // so that every permutation finishes on ROUND_LAST.
  function automatic logic [3:0] round_start(input int rounds);
    return 4'(ROUND_LAST + 1 - rounds);
  endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round-constant counter: loads a start index, steps by one while enabled
// and stops at ROUND_LAST, which it flags on last_o.
module ascon_round_counter
  import ascon_ctrl_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] start_val_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       last_o
);

  assign last_o = (count_o == 4'(ROUND_LAST));

  // Load has priority over stepping; the count never runs past the last round.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= start_val_i;
    end else if (en_i && !last_o) begin
      count_o <= count_o + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_ctrl_seq.sv
// Ascon encryption control sequencer: drives the permutation, XOR and
// output enables through init, AD blocks, PT blocks and finalisation.
// Optional feature: define ASCON_CTRL_ABORT_EN to add abort_i, which
// returns the FSM to IDLE on the next edge without an end_o pulse.
//
// Handshake: data_ready_o is high in WAIT_AD/WAIT_PT (decoded from state
// only); a block transfers on any rising edge where data_ready_o and
// data_valid_i are both 1, otherwise the FSM holds in the wait state.
module ascon_ctrl_seq
  import ascon_ctrl_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEFAULT,
  parameter int ROUNDS_B = ROUNDS_B_DEFAULT,
  parameter int NB_AD    = 1,
  parameter int NB_PT    = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic [3:0] block_idx_o,
  output logic       init_o,
  output logic       en_perm_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_b_o,
  output logic       en_xor_key_e_o,
  output logic       en_xor_lsb_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       busy_o,
  output logic       end_o,
  output logic [3:0] state_o
);

  localparam logic [3:0] START_A = round_start(ROUNDS_A);
  localparam logic [3:0] START_B = round_start(ROUNDS_B);
  localparam logic [3:0] LAST_AD = 4'(NB_AD - 1);
  localparam logic [3:0] LAST_PT = 4'(NB_PT - 1);

  ctrl_state_t state, nxt_state;
  logic [3:0]  block_idx, nxt_bidx;
  logic        cnt_load, cnt_en, cnt_last;
  logic [3:0]  cnt_start, cnt_count, nxt_round;
  logic        nxt_last, nxt_entry;

  ascon_round_counter u_round_counter (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .load_i      (cnt_load),
    .start_val_i (cnt_start),
    .en_i        (cnt_en),
    .count_o     (cnt_count),
    .last_o      (cnt_last)
  );

  assign round_o      = cnt_count;
  assign block_idx_o  = block_idx;
  assign state_o      = state;
  assign data_ready_o = (state == WAIT_AD) || (state == WAIT_PT);

  // Next state, counter control and block index, plus a look-ahead of the
  // round index so the enables can be registered for the coming cycle.
  always_comb begin
    nxt_state = state;
    nxt_bidx  = block_idx;
    cnt_load  = 1'b0;
    cnt_start = START_A;
    cnt_en    = 1'b0;
    case (state)
      IDLE:    if (start_i) nxt_state = INIT;
      INIT: begin
        nxt_state = PA_INIT;
        cnt_load  = 1'b1;
      end
      PA_INIT: begin
        if (cnt_last) begin
          nxt_state = WAIT_AD;
          nxt_bidx  = '0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      WAIT_AD: begin
        if (data_valid_i) begin
          nxt_state = PB_AD;
          cnt_load  = 1'b1;
          cnt_start = START_B;
        end
      end
      PB_AD: begin
        if (!cnt_last) begin
          cnt_en = 1'b1;
        end else if (block_idx == LAST_AD) begin
          nxt_state = WAIT_PT;
          nxt_bidx  = '0;
        end else begin
          nxt_state = WAIT_AD;
          nxt_bidx  = block_idx + 4'd1;
        end
      end
      WAIT_PT: begin
        if (data_valid_i) begin
          cnt_load = 1'b1;
          if (block_idx == LAST_PT) begin
            nxt_state = FINAL;
          end else begin
            nxt_state = PB_PT;
            cnt_start = START_B;
          end
        end
      end
      PB_PT: begin
        if (cnt_last) begin
          nxt_state = WAIT_PT;
          nxt_bidx  = block_idx + 4'd1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      FINAL: begin
        if (cnt_last) nxt_state = END;
        else          cnt_en = 1'b1;
      end
      END:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
`ifdef ASCON_CTRL_ABORT_EN
    if (abort_i) begin
      nxt_state = IDLE;
      nxt_bidx  = '0;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
    end
`endif
    nxt_round = cnt_load ? cnt_start : (cnt_en ? cnt_count + 4'd1 : cnt_count);
    nxt_last  = (nxt_round == 4'(ROUND_LAST));
    nxt_entry = (nxt_state != state);
  end

  // State register and registered enables for the cycle being entered.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      block_idx      <= '0;
      init_o         <= 1'b0;
      en_perm_o      <= 1'b0;
      en_xor_data_o  <= 1'b0;
      en_xor_key_b_o <= 1'b0;
      en_xor_key_e_o <= 1'b0;
      en_xor_lsb_o   <= 1'b0;
      en_cipher_o    <= 1'b0;
      en_tag_o       <= 1'b0;
      busy_o         <= 1'b0;
      end_o          <= 1'b0;
    end else begin
      state          <= nxt_state;
      block_idx      <= nxt_bidx;
      init_o         <= (nxt_state == INIT);
      en_perm_o      <= nxt_state inside {PA_INIT, PB_AD, PB_PT, FINAL};
      en_xor_data_o  <= nxt_entry && (nxt_state inside {PB_AD, PB_PT, FINAL});
      en_xor_key_b_o <= nxt_entry && (nxt_state == FINAL);
      en_xor_key_e_o <= nxt_last && (nxt_state inside {PA_INIT, FINAL});
      en_xor_lsb_o   <= nxt_last && (nxt_state == PB_AD) && (nxt_bidx == LAST_AD);
      en_cipher_o    <= nxt_entry && (nxt_state inside {PB_PT, FINAL});
      en_tag_o       <= nxt_last && (nxt_state == FINAL);
      busy_o         <= (nxt_state != IDLE);
      end_o          <= (nxt_state == END);
    end
  end

endmodule

// File: doc/ascon_ctrl_seq.md
ASCON_CTRL_SEQ -- requirements
Module: ascon_ctrl_seq

Interface
REQ-001 The block SHALL have parameter ROUNDS_A, default 12, giving the p^a round count for initialisation and finalisation (legal 1..12).
REQ-002 The block SHALL have parameter ROUNDS_B, default 6, giving the p^b round count for data blocks (legal 1..12).
REQ-003 The block SHALL have parameter NB_AD, default 1, giving the associated-data block count (legal 1..15).
REQ-004 The block SHALL have parameter NB_PT, default 3, giving the plaintext block count (legal 1..15).
REQ-005 The block SHALL have clock_i, input, 1 bit: single clock; all flops rising-edge.
REQ-006 The block SHALL have reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have start_i, input, 1 bit: request a full encryption sequence.
REQ-008 The block SHALL have data_valid_i, input, 1 bit: upstream block word available.
REQ-009 The block SHALL have data_ready_o, output, 1 bit: controller accepts a block this cycle.
REQ-010 The block SHALL have round_o, output, 4 bits: round-constant index for the permutation.
REQ-011 The block SHALL have block_idx_o, output, 4 bits: index of the current AD or PT block.
REQ-012 The block SHALL have the following 1-bit outputs: init_o, en_perm_o, en_xor_data_o, en_xor_key_b_o, en_xor_key_e_o, en_xor_lsb_o, en_cipher_o, en_tag_o, busy_o and end_o.

Function
REQ-013 FSM states SHALL be IDLE, INIT, PA_INIT, WAIT_AD, PB_AD, WAIT_PT, PB_PT, FINAL and END.
REQ-014 start_i SHALL be sampled only in IDLE: IDLE->INIT; start_i in any other state is ignored.
REQ-015 INIT SHALL last 1 cycle with init_o=1 (load IV||K||N), then go to PA_INIT.
REQ-016 In PA_INIT and FINAL, round_o SHALL step 12-ROUNDS_A..11, one per cycle, with en_perm_o=1.
REQ-017 In PB_AD and PB_PT, round_o SHALL step 12-ROUNDS_B..11, one per cycle, with en_perm_o=1.
REQ-018 en_xor_key_e_o SHALL be 1 on the last round cycle of both PA_INIT and FINAL.
REQ-019 In WAIT_AD and WAIT_PT, data_ready_o SHALL be 1 (combinational from state); a transfer occurs when data_valid_i=1 in that cycle, else the FSM holds.
REQ-020 WAIT_AD SHALL go to PB_AD on transfer; the first PB_AD cycle SHALL assert en_xor_data_o.
REQ-021 The last round of the last AD block SHALL assert en_xor_lsb_o (domain separation).
REQ-022 WAIT_PT SHALL go to PB_PT on transfer for blocks 0..NB_PT-2; the first PB_PT cycle SHALL assert en_xor_data_o and en_cipher_o.
REQ-023 The transfer of the last PT block SHALL enter FINAL; its first cycle SHALL assert en_xor_data_o, en_cipher_o and en_xor_key_b_o.
REQ-024 The last FINAL round SHALL also assert en_tag_o.
REQ-025 END SHALL last 1 cycle with end_o=1, then go to IDLE.
REQ-026 block_idx_o SHALL reset to 0 on entering WAIT_AD from PA_INIT and on leaving the last AD block, increment after each block, and wrap only by reset to 0.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 With data_valid_i held at 1 and default parameters, end_o SHALL be 1 in the 48th cycle after the edge sampling start_i.

Reset
REQ-029 reset_i=1 SHALL immediately force IDLE, counters to 0 and every output to 0, including mid-sequence.
REQ-030 Release of reset_i SHALL be synchronised; the first start_i SHALL be honoured on the first edge after release.

Configuration
REQ-031 With macro ASCON_CTRL_ABORT_EN defined, the block SHALL add an input abort_i (1 bit) that forces IDLE on the next edge from any state, with no end_o pulse.
REQ-032 Without ASCON_CTRL_ABORT_EN, the abort_i port and its logic SHALL be absent.

Structure
REQ-033 Package ascon_ctrl_pkg SHALL hold the state enum, ROUND_LAST=11 and the default round counts.
REQ-034 The round counter SHALL be sub-module ascon_round_counter, with load start value, enable, count_o and last_o outputs.

Verification
REQ-035 Reset then start_i pulse, data_valid_i=1, defaults -> end_o single pulse at cycle 48; busy_o 1 during cycles 1..48.
REQ-036 Same run -> round_o sequence 0..11 (PA_INIT), 6..11 per block, 0..11 (FINAL); en_xor_key_e_o pulses exactly 2 times.
REQ-037 data_valid_i=0 for 5 cycles in WAIT_PT -> FSM holds, data_ready_o stays 1, and end_o is delayed by exactly 5 cycles.
REQ-038 reset_i asserted during PB_AD round 8 -> all outputs 0 in the same cycle; a new start_i after release completes normally.
REQ-039 ROUNDS_B=8, NB_AD=2, NB_PT=1 -> PB rounds 4..11, en_xor_lsb_o once at the end of block 1, and FINAL entered directly from the first PT transfer.
REQ-040 With ASCON_CTRL_ABORT_EN, abort_i in FINAL -> IDLE next cycle with end_o never asserted.
